// File: rtl/demod_frame_ctrl.sv
// Receive-side frame controller for the 4-ary correlation demodulator: arms the demodulator,
// samples symbols once per symbol period, packs them into bytes and parses length-prefixed frames.
module demod_frame_ctrl #(
  parameter int unsigned SYM_PERIOD   = 32,
  parameter int unsigned SAMPLE_PHASE = 16,
  parameter int unsigned REARM_CYCLES = 4,
  parameter int unsigned TIMEOUT_SYMS = 64
) (
  input  logic       clk_fast,
  input  logic       rst,
  input  logic       enable,
  input  logic       demod_valid,
  input  logic [1:0] demod_sym,
  output logic       demod_rst_n,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic [7:0] frame_len,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CntW          = $clog2(SYM_PERIOD);
  localparam int unsigned TimeoutCycles = TIMEOUT_SYMS * SYM_PERIOD;
  localparam int unsigned ToW           = $clog2(TimeoutCycles);
  localparam int unsigned RaW           = $clog2(REARM_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle, StRearm, StWaitSync, StLen, StPayload, StDone, StErr
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   sym_cnt_q, sym_cnt_d;
  logic [1:0]        sym_idx_q, sym_idx_d;
  logic [5:0]        sh_q, sh_d;
  logic [7:0]        bytes_left_q, bytes_left_d;
  logic [7:0]        byte_data_q, byte_data_d;
  logic              byte_valid_q, byte_valid_d;
  logic [7:0]        frame_len_q, frame_len_d;
  logic              valid_q;
  logic [ToW-1:0]    to_cnt_q, to_cnt_d;
  logic [RaW-1:0]    ra_cnt_q, ra_cnt_d;

  logic       rise, fall, strobe, byte_cmpl;
  logic [7:0] byte_full;

  assign rise      = demod_valid & ~valid_q;
  assign fall      = ~demod_valid & valid_q;
  assign strobe    = (sym_cnt_q == CntW'(SAMPLE_PHASE));
  // Only six bits of history are kept; the incoming symbol completes the byte.
  assign byte_full = {sh_q, demod_sym};
  assign byte_cmpl = strobe && (sym_idx_q == 2'd3);

  always_comb begin
    state_d      = state_q;
    sym_cnt_d    = '0;
    sym_idx_d    = sym_idx_q;
    sh_d         = sh_q;
    bytes_left_d = bytes_left_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = byte_valid_q & ~byte_ready;
    frame_len_d  = frame_len_q;
    to_cnt_d     = '0;
    ra_cnt_d     = '0;
    demod_rst_n  = 1'b1;
    frame_done   = 1'b0;
    frame_err    = 1'b0;

    unique case (state_q)
      StIdle: begin
        demod_rst_n = 1'b0;
        if (enable) state_d = StRearm;
      end
      StRearm: begin
        demod_rst_n = 1'b0;
        ra_cnt_d    = ra_cnt_q + 1'b1;
        if (ra_cnt_q == RaW'(REARM_CYCLES - 1)) state_d = StWaitSync;
      end
      StWaitSync: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (!enable) begin
          state_d = StIdle;
        end else if (rise) begin
          state_d   = StLen;
          sym_idx_d = '0;
          sh_d      = '0;
        end else if (to_cnt_q == ToW'(TimeoutCycles - 1)) begin
          state_d = StRearm;
        end
      end
      StLen, StPayload: begin
        // Loss of the symbol stream wins over a strobe in the same cycle.
        if (fall) begin
          state_d = StErr;
        end else begin
          sym_cnt_d = sym_cnt_q + 1'b1;
          if (strobe) begin
            sh_d      = byte_full[5:0];
            sym_idx_d = sym_idx_q + 1'b1;
          end
          if (byte_cmpl && state_q == StLen) begin
            frame_len_d  = byte_full;
            bytes_left_d = byte_full;
            state_d      = (byte_full == 8'd0) ? StErr : StPayload;
          end else if (byte_cmpl) begin
            if (byte_valid_q && !byte_ready) begin
              state_d = StErr;
            end else begin
              byte_data_d  = byte_full;
              byte_valid_d = 1'b1;
              bytes_left_d = bytes_left_q - 8'd1;
              if (bytes_left_q == 8'd1) state_d = StDone;
            end
          end
        end
      end
      StDone: begin
        if (!byte_valid_q) begin
          frame_done = 1'b1;
          state_d    = enable ? StRearm : StIdle;
        end
      end
      StErr: begin
        frame_err    = 1'b1;
        byte_valid_d = 1'b0;
        state_d      = enable ? StRearm : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_fast or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      sym_cnt_q    <= '0;
      sym_idx_q    <= '0;
      sh_q         <= '0;
      bytes_left_q <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      frame_len_q  <= '0;
      valid_q      <= 1'b0;
      to_cnt_q     <= '0;
      ra_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      sym_cnt_q    <= sym_cnt_d;
      sym_idx_q    <= sym_idx_d;
      sh_q         <= sh_d;
      bytes_left_q <= bytes_left_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      frame_len_q  <= frame_len_d;
      valid_q      <= demod_valid;
      to_cnt_q     <= to_cnt_d;
      ra_cnt_q     <= ra_cnt_d;
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign frame_len  = frame_len_q;
  assign busy       = (state_q != StIdle);

endmodule
